// File: rtl/baud_pkg.sv
// Shared constants and a divisor calculator for the fractional baud tick generator.
package baud_pkg;

  localparam int OVS_8          = 8;
  localparam int OVS_16         = 16;
  localparam int DEF_INT_W      = 16;
  localparam int DEF_FRAC_W     = 8;
  localparam int DEF_DIV_INT    = 54;
  localparam int DEF_DIV_FRAC   = 65;
  localparam int DEF_OVS16      = 1;

  typedef struct packed {
    logic [DEF_INT_W-1:0]  div_int;
    logic [DEF_FRAC_W-1:0] div_frac;
  } div_t;

  // Rounded fixed-point divisor clk_freq / (baud * ovs) in units of 2^-DEF_FRAC_W cycles.
  function automatic div_t calc_div(input longint unsigned clk_freq,
                                    input longint unsigned baud,
                                    input int unsigned     ovs);
    longint unsigned num;
    longint unsigned den;
    longint unsigned q;
    div_t            res;
    num          = clk_freq << DEF_FRAC_W;
    den          = baud * longint'(ovs);
    q            = (num + (den >> 1)) / den;
    res.div_int  = q[DEF_INT_W+DEF_FRAC_W-1:DEF_FRAC_W];
    res.div_frac = q[DEF_FRAC_W-1:0];
    return res;
  endfunction

endpackage

// File: rtl/frac_clk_divider.sv
// Fractional interval counter: emits a one-cycle pulse in the last cycle of each
// div_int + carry interval, carrying the fractional remainder between intervals.
module frac_clk_divider
  import baud_pkg::*;
#(
  parameter int INT_W  = 16,
  parameter int FRAC_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [INT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              rx_tick
);

  logic [INT_W-1:0]  cnt_r;
  logic [FRAC_W-1:0] frac_acc_r;
  logic [FRAC_W:0]   frac_sum_s;
  logic [INT_W:0]    period_s;
  logic              last_s;

  // Interval length for the current interval, stretched by one on fractional carry
  always_comb begin
    frac_sum_s = {1'b0, frac_acc_r} + {1'b0, div_frac};
    period_s   = {1'b0, div_int} + {{INT_W{1'b0}}, frac_sum_s[FRAC_W]};
    last_s     = ({1'b0, cnt_r} == (period_s - {{INT_W{1'b0}}, 1'b1}));
    rx_tick    = en && !clr && last_s;
  end

  // Cycle counter and fractional accumulator
  always_ff @(posedge clk) begin
    if (rst || clr || !en) begin
      cnt_r      <= {INT_W{1'b0}};
      frac_acc_r <= {FRAC_W{1'b0}};
    end else if (last_s) begin
      cnt_r      <= {INT_W{1'b0}};
      frac_acc_r <= frac_sum_s[FRAC_W-1:0];
    end else begin
      cnt_r      <= cnt_r + {{(INT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/frac_baud_tick_gen.sv
// UART baud tick source: fractional oversample ticks, bit ticks and a shadowed config.
// Optional tx_tick statistics counter is built when BAUD_TICK_STATS_EN is defined.
module frac_baud_tick_gen
  import baud_pkg::*;
#(
  parameter int INT_W            = 16,
  parameter int FRAC_W           = 8,
  parameter int DEFAULT_DIV_INT  = DEF_DIV_INT,
  parameter int DEFAULT_DIV_FRAC = DEF_DIV_FRAC,
  parameter int DEFAULT_OVS16    = DEF_OVS16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [INT_W-1:0]  cfg_div_int,
  input  logic [FRAC_W-1:0] cfg_div_frac,
  input  logic              cfg_ovs16,
  output logic              cfg_err,
  input  logic              rx_resync,
  output logic              rx_tick,
  output logic              tx_tick,
`ifdef BAUD_TICK_STATS_EN
  input  logic              stats_clr,
  output logic [31:0]       tx_tick_count,
`endif
  output logic [3:0]        ovs_phase
);

  logic [INT_W-1:0]  div_int_r;
  logic [FRAC_W-1:0] div_frac_r;
  logic              ovs16_r;
  logic [INT_W-1:0]  sh_int_r;
  logic [FRAC_W-1:0] sh_frac_r;
  logic              sh_ovs16_r;
  logic              pending_r;
  logic              accept_s;
  logic              reject_s;
  logic              apply_s;
  logic              clr_s;
  logic              tick_due_s;
  logic              last_phase_s;

  frac_clk_divider #(
    .INT_W  (INT_W),
    .FRAC_W (FRAC_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clr      (clr_s),
    .div_int  (div_int_r),
    .div_frac (div_frac_r),
    .rx_tick  (tick_due_s)
  );

  // Handshake decode; a pending shadow lands right after a bit tick or whenever idle
  always_comb begin
    accept_s     = cfg_valid && cfg_ready && (cfg_div_int >= INT_W'(2));
    reject_s     = cfg_valid && cfg_ready && (cfg_div_int <  INT_W'(2));
    apply_s      = pending_r && (tx_tick || !en);
    clr_s        = rx_resync || apply_s;
    last_phase_s = ovs16_r ? (ovs_phase == 4'(OVS_16 - 1)) : (ovs_phase == 4'(OVS_8 - 1));
  end

  // Active divisor, shadow register and config handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      div_int_r  <= INT_W'(DEFAULT_DIV_INT);
      div_frac_r <= FRAC_W'(DEFAULT_DIV_FRAC);
      ovs16_r    <= (DEFAULT_OVS16 != 0);
      sh_int_r   <= {INT_W{1'b0}};
      sh_frac_r  <= {FRAC_W{1'b0}};
      sh_ovs16_r <= 1'b0;
      pending_r  <= 1'b0;
      cfg_ready  <= 1'b1;
      cfg_err    <= 1'b0;
    end else begin
      cfg_err <= reject_s;
      if (apply_s) begin
        div_int_r  <= sh_int_r;
        div_frac_r <= sh_frac_r;
        ovs16_r    <= sh_ovs16_r;
        pending_r  <= 1'b0;
        cfg_ready  <= 1'b1;
      end else if (accept_s) begin
        sh_int_r   <= cfg_div_int;
        sh_frac_r  <= cfg_div_frac;
        sh_ovs16_r <= cfg_ovs16;
        pending_r  <= 1'b1;
        cfg_ready  <= 1'b0;
      end else begin
        pending_r  <= pending_r;
      end
    end
  end

  // Registered ticks; phase advances the cycle after each rx_tick so it names the tick in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_tick   <= 1'b0;
      tx_tick   <= 1'b0;
      ovs_phase <= 4'd0;
    end else begin
      rx_tick <= tick_due_s;
      tx_tick <= tick_due_s && last_phase_s;
      if (!en || clr_s) begin
        ovs_phase <= 4'd0;
      end else if (rx_tick) begin
        ovs_phase <= last_phase_s ? 4'd0 : (ovs_phase + 4'd1);
      end else begin
        ovs_phase <= ovs_phase;
      end
    end
  end

`ifdef BAUD_TICK_STATS_EN
  // Saturating bit-tick counter; clear wins over a coincident tick
  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      tx_tick_count <= 32'd0;
    end else if (tx_tick && (tx_tick_count != 32'hFFFF_FFFF)) begin
      tx_tick_count <= tx_tick_count + 32'd1;
    end else begin
      tx_tick_count <= tx_tick_count;
    end
  end
`endif

endmodule

// File: tb/tb_frac_baud_tick_gen.sv
// Scoreboard bench: an interval-level reference model predicts every cycle's outputs,
// a negedge monitor compares them, and directed tests check the headline spacings.
module tb_frac_baud_tick_gen;
  import baud_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [15:0] cfg_div_int = 16'd0;
  logic [7:0]  cfg_div_frac = 8'd0;
  logic        cfg_ovs16 = 1'b0;
  logic        cfg_err;
  logic        rx_resync = 1'b0;
  logic        rx_tick;
  logic        tx_tick;
  logic [3:0]  ovs_phase;
`ifdef BAUD_TICK_STATS_EN
  logic        stats_clr = 1'b0;
  logic [31:0] tx_tick_count;
`endif

  frac_baud_tick_gen dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_div_int  (cfg_div_int),
    .cfg_div_frac (cfg_div_frac),
    .cfg_ovs16    (cfg_ovs16),
    .cfg_err      (cfg_err),
    .rx_resync    (rx_resync),
    .rx_tick      (rx_tick),
    .tx_tick      (tx_tick),
`ifdef BAUD_TICK_STATS_EN
    .stats_clr    (stats_clr),
    .tx_tick_count(tx_tick_count),
`endif
    .ovs_phase    (ovs_phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst;
    bit rx;
    bit tx;
    bit err;
    bit ready;
    int phase;
  } exp_t;

  exp_t exp_q[$];
  int   tk_q[$];
  int   tx_q[$];
  int   err_cnt = 0;
  int   edge_n = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  // Reference model state: interval start edge S, next tick at S + div + carry
  int m_int = 54, m_frac = 65, m_ovs16 = 1, m_acc = 0, m_S = 0, m_idx = 0;
  int m_pend = 0, m_ready = 1, m_tx_prev = 0, m_due = 0;
  int sh_int = 0, sh_frac = 0, sh_ovs16 = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: actual %0d required %0d", name, act, req);
  endtask

  task automatic model_step();
    exp_t r;
    bit   apply, tick, accept;
    int   ovs;
    edge_n++;
    r = '{default: 0};
    if (rst) begin
      m_int = 54; m_frac = 65; m_ovs16 = 1; m_acc = 0; m_S = edge_n; m_idx = 0;
      m_pend = 0; m_ready = 1; m_tx_prev = 0;
      r.rst = 1'b1; r.ready = 1'b1;
    end else begin
      ovs    = (m_ovs16 != 0) ? 16 : 8;
      apply  = (m_pend != 0) && ((m_tx_prev != 0) || !en);
      tick   = en && !rx_resync && !apply && (edge_n == m_S + m_int + (m_acc + m_frac) / 256);
      r.rx    = tick;
      r.phase = m_idx % ovs;
      r.tx    = tick && ((m_idx % ovs) == ovs - 1);
      r.err   = cfg_valid && (m_ready != 0) && (cfg_div_int < 16'd2);
      accept  = cfg_valid && (m_ready != 0) && (cfg_div_int >= 16'd2);
      if (tick) begin
        m_acc = (m_acc + m_frac) % 256; m_S = edge_n; m_idx++;
      end
      if (!en || rx_resync || apply) begin
        m_S = edge_n; m_acc = 0; m_idx = 0;
      end
      if (apply) begin
        m_int = sh_int; m_frac = sh_frac; m_ovs16 = sh_ovs16; m_pend = 0; m_ready = 1;
      end else if (accept) begin
        sh_int = int'(cfg_div_int); sh_frac = int'(cfg_div_frac); sh_ovs16 = int'(cfg_ovs16);
        m_pend = 1; m_ready = 0;
      end
      r.ready   = (m_ready != 0);
      m_tx_prev = r.tx;
    end
    m_due = m_S + m_int + (m_acc + m_frac) / 256;
    exp_q.push_back(r);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor: one scoreboard entry per cycle
  initial forever begin
    exp_t r;
    @(negedge clk);
    if (rx_tick === 1'b1) tk_q.push_back(edge_n);
    if (tx_tick === 1'b1) tx_q.push_back(edge_n);
    if (cfg_err === 1'b1) err_cnt++;
    n_chk++;
    if (exp_q.size() == 0) begin
      $display("FAIL scoreboard_empty: actual 0 entries required 1 at edge %0d", edge_n);
    end else begin
      r = exp_q.pop_front();
      if (rx_tick === r.rx && tx_tick === r.tx && cfg_err === r.err && cfg_ready === r.ready &&
          (!(r.rx || r.rst) || ovs_phase === 4'(r.phase)))
        n_pass++;
      else
        $display("FAIL edge_%0d: actual rx=%b tx=%b err=%b rdy=%b ph=%0d required rx=%b tx=%b err=%b rdy=%b ph=%0d",
                 edge_n, rx_tick, tx_tick, cfg_err, cfg_ready, ovs_phase, r.rx, r.tx, r.err, r.ready, r.phase);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic offer(input int di, input int df, input int o);
    cfg_valid = 1'b1; cfg_div_int = 16'(di); cfg_div_frac = 8'(df); cfg_ovs16 = (o != 0);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_ticks(input string name, input int n, input int budget);
    int start = tk_q.size();
    int k = 0;
    while (tk_q.size() < start + n && k < budget) begin
      @(negedge clk); k++;
    end
    if (tk_q.size() < start + n) check(name, tk_q.size() - start, n);
  endtask

  task automatic wait_ready(input string name, input int budget);
    int k = 0;
    while (cfg_ready !== 1'b1 && k < budget) begin
      @(negedge clk); k++;
    end
    if (cfg_ready !== 1'b1) check(name, 0, 1);
  endtask

  initial begin
    div_t d;
    int   e0, td, k;
    @(negedge clk);
    cyc(3);

    d = calc_div(64'd100_000_000, 64'd115200, 16);
    check("calc_div_int", d.div_int, 54);
    check("calc_div_frac", d.div_frac, 65);

    // Test 1: defaults
    rst = 1'b0; en = 1'b1; e0 = edge_n + 1;
    tk_q.delete(); tx_q.delete();
    wait_ticks("t1_ticks", 16, 1200);
    if (tk_q.size() >= 16 && tx_q.size() >= 1) begin
      check("t1_first_latency", tk_q[0] - (e0 - 1), 54);
      check("t1_space1", tk_q[1] - tk_q[0], 54);
      check("t1_space2", tk_q[2] - tk_q[1], 54);
      check("t1_space3", tk_q[3] - tk_q[2], 55);
      check("t1_space5_acc4", tk_q[4] - tk_q[3], 54);
      check("t1_space8", tk_q[7] - tk_q[6], 55);
      check("t1_tx_on_16th", tx_q[0], tk_q[15]);
    end

    // Test 2: reconfigure during traffic
    cyc(100);
    offer(10, 0, 0);
    check("t2_ready_low", cfg_ready, 0);
    wait_ready("t2_apply_timeout", 1200);
    tk_q.delete(); tx_q.delete();
    wait_ticks("t2_ticks", 17, 300);
    if (tk_q.size() >= 2) check("t2_rx_space", tk_q[1] - tk_q[0], 10);
    if (tx_q.size() >= 2) check("t2_tx_space", tx_q[1] - tx_q[0], 80);

    // Test 3: illegal divisor
    err_cnt = 0;
    offer(1, 5, 1);
    cyc(3);
    check("t3_err_pulses", err_cnt, 1);
    check("t3_ready_high", cfg_ready, 1);
    tk_q.delete();
    wait_ticks("t3_ticks", 2, 100);
    if (tk_q.size() >= 2) check("t3_rx_space", tk_q[1] - tk_q[0], 10);

    // Test 4: resync exactly on a due tick
    offer(54, 65, 1);
    wait_ready("t4_apply_timeout", 1000);
    cyc(30);
    k = 0;
    while (m_due != edge_n + 1 && k < 200) begin
      @(negedge clk); k++;
    end
    rx_resync = 1'b1; td = edge_n + 1;
    tk_q.delete();
    @(negedge clk);
    rx_resync = 1'b0;
    wait_ticks("t4_ticks", 1, 100);
    if (tk_q.size() >= 1) check("t4_next_after_resync", tk_q[0] - td, 54);

    // Test 5: config while disabled
    cyc(20);
    en = 1'b0;
    cyc(5);
    offer(20, 128, 0);
    cyc(2);
    check("t5_ready_after_apply", cfg_ready, 1);
    en = 1'b1; e0 = edge_n + 1;
    tk_q.delete();
    wait_ticks("t5_ticks", 2, 100);
    if (tk_q.size() >= 2) begin
      check("t5_first_latency", tk_q[0] - (e0 - 1), 20);
      check("t5_carry_space", tk_q[1] - tk_q[0], 21);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rx_resync = ($urandom % 50 == 0);
      if ($urandom % 200 == 0) en = !en;
      rst = ($urandom % 1500 == 0);
      cfg_valid = ($urandom % 40 == 0);
      cfg_div_int = 16'($urandom_range(0, 30));
      cfg_div_frac = 8'($urandom);
      cfg_ovs16 = 1'($urandom);
      @(negedge clk);
    end
    rx_resync = 1'b0; rst = 1'b0; cfg_valid = 1'b0; en = 1'b1;
    cyc(10);

`ifdef BAUD_TICK_STATS_EN
    // Test 6: bit counter
    rst = 1'b1; cyc(2);
    rst = 1'b0; en = 1'b0;
    offer(4, 0, 0);
    cyc(2);
    en = 1'b1;
    tx_q.delete();
    k = 0;
    while (tx_q.size() < 3 && k < 300) begin
      @(negedge clk); k++;
    end
    cyc(2);
    check("t6_count3", tx_tick_count, 3);
    k = 0;
    while (tx_tick !== 1'b1 && k < 100) begin
      @(negedge clk); k++;
    end
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    check("t6_clr_on_tick", tx_tick_count, 0);
    cyc(1);
    check("t6_clr_hold", tx_tick_count, 0);
`endif

    cyc(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
